// File: rtl/mux_4to1_case_reg.sv
// Four-way WIDTH-bit lane selector: a combinational output plus a registered
// copy carrying a one-cycle valid pulse and the select value that produced it.
module mux_4to1_case_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out_comb,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic [1:0]       sel_q
);

  // Capture protocol: en is a one-cycle strobe with no backpressure. Each
  // edge with en=1 (and rst=0) samples out_comb/sel, and out_valid is high
  // for exactly the following cycle; en held high streams one sample/cycle.

  logic [WIDTH-1:0] w_sel_data;
  logic [WIDTH-1:0] r_out;
  logic             r_out_valid;
  logic [1:0]       r_sel_q;

  // An X/Z select yields all-X in simulation; synthesis may optimise it away.
  always_comb begin
    w_sel_data = {WIDTH{1'bx}};
    case (sel)
      2'b00:   w_sel_data = a;
      2'b01:   w_sel_data = b;
      2'b10:   w_sel_data = c;
      2'b11:   w_sel_data = d;
      default: w_sel_data = {WIDTH{1'bx}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_sel_q     <= 2'b00;
    end else if (en) begin
      r_out       <= w_sel_data;
      r_out_valid <= 1'b1;
      r_sel_q     <= sel;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_comb  = w_sel_data;
  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign sel_q     = r_sel_q;

endmodule

// File: tb/tb_mux_4to1_case_reg.sv
// Directed self-checking bench for mux_4to1_case_reg with hand-computed
// expectations and a small expected queue for the registered sweep.
module tb_mux_4to1_case_reg;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] a, b, c, d;
  logic [1:0]   sel;
  logic [W-1:0] out_comb;
  logic [W-1:0] out;
  logic         out_valid;
  logic [1:0]   sel_q;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] sweep_exp [4];
  logic [W-1:0] exp_val;

  mux_4to1_case_reg #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .sel       (sel),
    .out_comb  (out_comb),
    .out       (out),
    .out_valid (out_valid),
    .sel_q     (sel_q)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] vc, input logic [W-1:0] vd);
    a = va; b = vb; c = vc; d = vd;
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sweep_exp[0] = 4'h4;
    sweep_exp[1] = 4'h1;
    sweep_exp[2] = 4'h9;
    sweep_exp[3] = 4'h3;

    // Reset held for two edges with en high and operands live.
    rst = 1'b1;
    en  = 1'b1;
    sel = 2'd0;
    set_ops(4'h4, 4'h1, 4'h9, 4'h3);
    tick();
    tick();
    check_eq("rst_out", {28'd0, out}, 32'h0);
    check_eq("rst_valid", {31'd0, out_valid}, 32'h0);
    check_eq("rst_sel_q", {30'd0, sel_q}, 32'h0);
    sel = 2'd2;
    #1;
    check_eq("rst_comb_follows", {28'd0, out_comb}, 32'h9);

    // Combinational sweep, one step every 5 time units.
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      #1;
      check_eq($sformatf("comb_sel%0d", i), {28'd0, out_comb},
               {28'd0, sweep_exp[i]});
      #4;
    end

    // Registered sweep on consecutive enabled edges.
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = i[1:0];
      exp_q.push_back(sweep_exp[i]);
      tick();
      exp_val = exp_q.pop_front();
      check_eq($sformatf("reg_out%0d", i), {28'd0, out}, {28'd0, exp_val});
      check_eq($sformatf("reg_sel_q%0d", i), {30'd0, sel_q}, i);
      check_eq($sformatf("reg_valid%0d", i), {31'd0, out_valid}, 32'h1);
    end

    // Hold: capture sel=2, then three disabled cycles with churn on inputs.
    sel = 2'd2;
    tick();
    check_eq("hold_cap_out", {28'd0, out}, 32'h9);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sel = 2'($urandom_range(0, 3));
      set_ops(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      tick();
      check_eq($sformatf("hold_out%0d", i), {28'd0, out}, 32'h9);
      check_eq($sformatf("hold_sel_q%0d", i), {30'd0, sel_q}, 32'h2);
      check_eq($sformatf("hold_valid%0d", i), {31'd0, out_valid}, 32'h0);
    end

    // Independence: only b matters while sel=1.
    sel = 2'd1;
    b   = 4'hA;
    en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 4'($urandom_range(0, 15));
      c = 4'($urandom_range(0, 15));
      d = 4'($urandom_range(0, 15));
      #1;
      check_eq($sformatf("indep_comb%0d", i), {28'd0, out_comb}, 32'hA);
      tick();
      check_eq($sformatf("indep_out%0d", i), {28'd0, out}, 32'hA);
    end

    // Reset mid-stream with sel=3, d=F: capture is discarded.
    sel = 2'd3;
    d   = 4'hF;
    rst = 1'b1;
    tick();
    check_eq("midrst_out", {28'd0, out}, 32'h0);
    check_eq("midrst_valid", {31'd0, out_valid}, 32'h0);
    check_eq("midrst_sel_q", {30'd0, sel_q}, 32'h0);
    rst = 1'b0;
    tick();
    check_eq("resume_out", {28'd0, out}, 32'hF);
    check_eq("resume_sel_q", {30'd0, sel_q}, 32'h3);
    check_eq("resume_valid", {31'd0, out_valid}, 32'h1);
    en = 1'b0;
    tick();
    check_eq("resume_drop_valid", {31'd0, out_valid}, 32'h0);
    check_eq("resume_hold_out", {28'd0, out}, 32'hF);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_4to1_case_reg.md
Name: mux_4to1_case_reg

Overview:
- Four-input, one-output data selector. One of four WIDTH-bit operands is chosen by a 2-bit select, using a full case decode.
- Provides an unregistered selected value for same-cycle use.
- Provides a registered copy, with a valid flag and a select echo, for pipelined datapaths.
- Used as a generic lane-select primitive in datapath glue logic.

Parameters:
- WIDTH, 4, bit width of each data operand and of both outputs.

Ports:
- clk  input  1  rising-edge clock; all state updates on this edge.
- rst  input  1  reset, synchronous, active-high.
- en  input  1  capture enable for the registered output stage.
- a  input  WIDTH  operand selected when sel=0.
- b  input  WIDTH  operand selected when sel=1.
- c  input  WIDTH  operand selected when sel=2.
- d  input  WIDTH  operand selected when sel=3.
- sel  input  2  operand select.
- out_comb  output  WIDTH  combinational selected operand.
- out  output  WIDTH  registered selected operand.
- out_valid  output  1  high for the cycle after a capture.
- sel_q  output  2  select value that produced the current out.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, with ports named clk and rst.
- Combinational path:
  - out_comb = a when sel=2'b00, b when 2'b01, c when 2'b10, d when 2'b11.
  - Pure combinational. Zero latency. Independent of clk, rst and en.
  - Any sel or operand change reflects on out_comb in the same delta/cycle.
- Unknown select: if sel contains X/Z, out_comb drives all-X in simulation. A default branch assigns {WIDTH{1'bx}}. Synthesis is free to optimise this case.
- Register stage, on each rising clk edge:
  - rst=1: out <= 0, out_valid <= 0, sel_q <= 2'b00. Reset has priority over en.
  - rst=0, en=1: out <= the out_comb value at that edge; sel_q <= sel; out_valid <= 1.
  - rst=0, en=0: out and sel_q hold their values; out_valid <= 0.
- Latency: one cycle from an enabled capture edge to out/out_valid.
- Back-to-back captures: en held high gives a new sample every cycle, and out_valid stays high continuously.
- Reset mid-stream: a capture in progress is discarded. The outputs read zero/invalid the cycle after rst is sampled high.
- Operand width handling:
  - No arithmetic and no truncation.
  - Operands pass bit-exact.
  - Operands are all exactly WIDTH bits, and the output equals the selected operand on every bit.
- Operand independence: non-selected operands have no effect on either output.
- State: no state machine. The only state is the out, out_valid and sel_q registers.
- Power-up: register values before the first reset are undefined. The bench must apply rst for at least one edge.

Test Plan:
- Reset: rst=1 for 2 edges, with a=4'h4, b=4'h1, c=4'h9, d=4'h3, en=1 → out=0, out_valid=0, sel_q=0. out_comb still follows sel.
- Select sweep, combinational:
  - a=4'h4, b=4'h1, c=4'h9, d=4'h3; sel stepped 0,1,2,3 every 5 time units.
  - out_comb reads 4, 1, 9, 3 immediately on each step.
- Registered sweep:
  - Same operands, en=1, sel 0→3 on consecutive edges.
  - One cycle later, out = 4, 1, 9, 3 and sel_q = 0, 1, 2, 3, with out_valid high throughout.
- Hold:
  - Capture with sel=2 (out=9), then en=0 for 3 cycles while sel and operands change.
  - out stays 9 and sel_q stays 2; out_valid drops after one cycle.
- Independence: sel=1, b=4'hA; toggle a, c and d randomly → out_comb and the captured out remain 4'hA.
- Reset mid-stream: en=1 streaming, assert rst for one edge with sel=3 and d=4'hF → out=0 and out_valid=0 that cycle. Capture resumes on the next enabled edge.
